// File: rtl/jtkiwi_shram_arb.sv
// Shared 8 kB RAM arbiter between the main CPU and the sound/sub CPU.
// It serialises single-port RAM accesses, stalls the CPU that has to wait
// through its busy line, and returns registered read data to each side.
// Optional build macro: JTKIWI_ARB_RR_EN
//   defined   -> ties are granted round-robin against the last requester served
//   undefined -> ties always go to the main CPU
module jtkiwi_shram_arb #(
  parameter int AW     = 13,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          m_cs_i,
  input  logic          m_we_i,
  input  logic [AW-1:0] m_addr_i,
  input  logic [DW-1:0] m_din_i,
  output logic [DW-1:0] m_dout_o,
  output logic          m_busy_o,
  input  logic          s_cs_i,
  input  logic          s_we_i,
  input  logic [AW-1:0] s_addr_i,
  input  logic [DW-1:0] s_din_i,
  output logic [DW-1:0] s_dout_o,
  output logic          s_busy_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  output logic          ram_we_o,
  input  logic [DW-1:0] ram_dout_i
);

  typedef enum logic [1:0] {IDLE, ACC_M, ACC_S} state_t;

  localparam logic       LAST_M = 1'b1;
  localparam logic       LAST_S = 1'b0;
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);
`ifdef JTKIWI_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          we_q, we_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] m_dout_q, m_dout_d;
  logic [DW-1:0] s_dout_q, s_dout_d;
  logic          m_done_q, m_done_d;
  logic          s_done_q, s_done_d;
  logic          last_q, last_d;

  logic m_pend, s_pend, m_fin, s_fin, grant_m, grant_s, acc_fin;

  assign m_pend = m_cs_i & ~m_done_q;
  assign s_pend = s_cs_i & ~s_done_q;

  assign m_busy_o   = m_pend;
  assign s_busy_o   = s_pend;
  assign m_dout_o   = m_dout_q;
  assign s_dout_o   = s_dout_q;
  assign ram_addr_o = addr_q;
  assign ram_din_o  = din_q;
  assign ram_we_o   = we_q;

  // A write always completes on its first ACC edge, which is exactly the
  // cycle where the registered write strobe is still high.
  assign acc_fin = we_q | (cnt_q == LAT_M1);

  // Next-state decode: access sequencing, grants and per-requester results.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = 1'b0;
    cnt_d    = cnt_q;
    m_dout_d = m_dout_q;
    s_dout_d = s_dout_q;
    last_d   = last_q;
    m_fin    = 1'b0;
    s_fin    = 1'b0;
    grant_m  = 1'b0;
    grant_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_pend && s_pend) begin
          grant_m = !RR_EN || (last_q == LAST_S);
          grant_s = !grant_m;
        end else begin
          grant_m = m_pend;
          grant_s = s_pend;
        end
      end
      ACC_M: begin
        cnt_d = cnt_q + 2'd1;
        if (acc_fin) begin
          m_fin   = 1'b1;
          last_d  = LAST_M;
          state_d = IDLE;
          if (!we_q) m_dout_d = ram_dout_i;
          grant_s = s_pend;
        end
      end
      ACC_S: begin
        cnt_d = cnt_q + 2'd1;
        if (acc_fin) begin
          s_fin   = 1'b1;
          last_d  = LAST_S;
          state_d = IDLE;
          if (!we_q) s_dout_d = ram_dout_i;
          grant_m = m_pend;
        end
      end
      default: state_d = IDLE;
    endcase
    // Loser of a contended cycle is launched on the completing edge.
    if (grant_m) begin
      state_d = ACC_M;
      addr_d  = m_addr_i;
      din_d   = m_din_i;
      we_d    = m_we_i;
      cnt_d   = 2'd0;
    end else if (grant_s) begin
      state_d = ACC_S;
      addr_d  = s_addr_i;
      din_d   = s_din_i;
      we_d    = s_we_i;
      cnt_d   = 2'd0;
    end
    // Done sticks while cs is held so a lingering cs cannot re-trigger.
    m_done_d = m_cs_i & (m_done_q | m_fin);
    s_done_d = s_cs_i & (s_done_q | s_fin);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      cnt_q    <= 2'd0;
      m_dout_q <= '0;
      s_dout_q <= '0;
      m_done_q <= 1'b0;
      s_done_q <= 1'b0;
      last_q   <= LAST_S;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      m_dout_q <= m_dout_d;
      s_dout_q <= s_dout_d;
      m_done_q <= m_done_d;
      s_done_q <= s_done_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Directed bench for jtkiwi_shram_arb with RD_LAT=2 and a behavioural RAM.
module tb_jtkiwi_shram_arb;
  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m_cs, m_we, s_cs, s_we;
  logic [AW-1:0] m_addr, s_addr;
  logic [DW-1:0] m_din, s_din;
  logic [DW-1:0] m_dout, s_dout;
  logic          m_busy, s_busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            we_cnt = 0;
  int            n_assert = 0;
  int            n_fail = 0;

  jtkiwi_shram_arb #(.AW(AW), .DW(DW), .RD_LAT(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cs_i(m_cs), .m_we_i(m_we), .m_addr_i(m_addr), .m_din_i(m_din),
    .m_dout_o(m_dout), .m_busy_o(m_busy),
    .s_cs_i(s_cs), .s_we_i(s_we), .s_addr_i(s_addr), .s_din_i(s_din),
    .s_dout_o(s_dout), .s_busy_o(s_busy),
    .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_we_o(ram_we),
    .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int            base;
  logic [AW-1:0] win_a, lose_a;
  logic [DW-1:0] win_d, lose_d;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = DW'(i);
    mem[13'h0010] = 8'h11;
    mem[13'h0020] = 8'h22;
    mem[13'h1FFF] = 8'h81;
    for (int r = 0; r < 4; r++) begin
      mem[13'h0100 + 13'(r)] = 8'h40 + 8'(r);
      mem[13'h0200 + 13'(r)] = 8'h50 + 8'(r);
    end

    // Reset with both CPUs requesting reads
    rst_n = 1'b0;
    m_cs = 1'b1; m_we = 1'b0; m_addr = 13'h0010; m_din = 8'h00;
    s_cs = 1'b1; s_we = 1'b0; s_addr = 13'h0020; s_din = 8'h00;
    #2;
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_din", 32'(ram_din), 32'h0);
    chk("rst_m_dout", 32'(m_dout), 32'h0);
    chk("rst_s_dout", 32'(s_dout), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_m_busy", 32'(m_busy), 32'h1);
    chk("rst_s_busy", 32'(s_busy), 32'h1);
    tick();
    chk("first_grant_main", 32'(ram_addr), 32'h0010);
    tick();
    chk("m_busy_mid_read", 32'(m_busy), 32'h1);
    tick();
    chk("m_read_data", 32'(m_dout), 32'h11);
    chk("m_busy_after_read", 32'(m_busy), 32'h0);
    chk("s_b2b_grant_addr", 32'(ram_addr), 32'h0020);
    chk("s_busy_waiting", 32'(s_busy), 32'h1);
    tick();
    tick();
    chk("s_read_data", 32'(s_dout), 32'h22);
    chk("s_busy_after_read", 32'(s_busy), 32'h0);
    m_cs = 1'b0; s_cs = 1'b0;
    tick();

    // Uncontended main write
    m_cs = 1'b1; m_we = 1'b1; m_addr = 13'h0A5C; m_din = 8'h3C;
    #1;
    chk("wr_busy_same_cycle", 32'(m_busy), 32'h1);
    tick();
    chk("wr_ram_we_on", 32'(ram_we), 32'h1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h0A5C);
    chk("wr_ram_din", 32'(ram_din), 32'h3C);
    m_addr = 13'h0000; m_din = 8'hFF;
    tick();
    chk("wr_ram_we_off", 32'(ram_we), 32'h0);
    chk("wr_m_busy_low", 32'(m_busy), 32'h0);
    chk("wr_mem", 32'(mem[13'h0A5C]), 32'h3C);
    chk("wr_mem_untouched", 32'(mem[13'h0000]), 32'h00);
    chk("m_dout_held", 32'(m_dout), 32'h11);
    m_cs = 1'b0; m_we = 1'b0;
    tick();

    // Uncontended sub read at the top address
    s_cs = 1'b1; s_we = 1'b0; s_addr = 13'h1FFF;
    tick();
    chk("s_rd_addr", 32'(ram_addr), 32'h1FFF);
    chk("s_rd_busy0", 32'(s_busy), 32'h1);
    tick();
    chk("s_rd_busy1", 32'(s_busy), 32'h1);
    chk("s_rd_dout_old", 32'(s_dout), 32'h22);
    tick();
    chk("s_rd_data", 32'(s_dout), 32'h81);
    chk("s_rd_busy2", 32'(s_busy), 32'h0);
    s_cs = 1'b0;
    tick();

    // Four rounds of simultaneous reads: main then sub, back to back
    for (int r = 0; r < 4; r++) begin
      m_addr = 13'h0100 + 13'(r); s_addr = 13'h0200 + 13'(r);
      m_cs = 1'b1; s_cs = 1'b1;
      tick();
      chk("tie_first_main", 32'(ram_addr), 32'(13'h0100 + 13'(r)));
      tick();
      tick();
      chk("tie_m_data", 32'(m_dout), 32'(8'h40 + 8'(r)));
      chk("tie_then_sub", 32'(ram_addr), 32'(13'h0200 + 13'(r)));
      tick();
      tick();
      chk("tie_s_data", 32'(s_dout), 32'(8'h50 + 8'(r)));
      chk("tie_s_busy", 32'(s_busy), 32'h0);
      m_cs = 1'b0; s_cs = 1'b0;
      tick();
    end

    // Sub write held after completion: exactly one RAM write
    base = we_cnt;
    s_cs = 1'b1; s_we = 1'b1; s_addr = 13'h0777; s_din = 8'h5A;
    tick();
    tick();
    chk("hold_done", 32'(s_busy), 32'h0);
    for (int i = 0; i < 10; i++) tick();
    chk("hold_one_write", 32'(we_cnt - base), 32'h1);
    chk("hold_busy_low", 32'(s_busy), 32'h0);
    chk("hold_mem", 32'(mem[13'h0777]), 32'h5A);
    s_cs = 1'b0;
    tick();
    s_cs = 1'b1; s_din = 8'hA5;
    tick();
    chk("rearm_we", 32'(ram_we), 32'h1);
    tick();
    chk("rearm_two_writes", 32'(we_cnt - base), 32'h2);
    chk("rearm_mem", 32'(mem[13'h0777]), 32'hA5);
    s_cs = 1'b0; s_we = 1'b0;
    tick();

    // Tie right after a main access: fixed priority vs round-robin
    m_cs = 1'b1; m_we = 1'b1; m_addr = 13'h0333; m_din = 8'h77;
    tick();
    tick();
    m_cs = 1'b0; m_we = 1'b0;
    tick();
    m_addr = 13'h0010; s_addr = 13'h0020;
`ifdef JTKIWI_ARB_RR_EN
    win_a = 13'h0020; win_d = 8'h22; lose_a = 13'h0010; lose_d = 8'h11;
`else
    win_a = 13'h0010; win_d = 8'h11; lose_a = 13'h0020; lose_d = 8'h22;
`endif
    m_cs = 1'b1; s_cs = 1'b1;
    tick();
    chk("last_tie_winner", 32'(ram_addr), 32'(win_a));
    tick();
    tick();
    chk("last_tie_loser", 32'(ram_addr), 32'(lose_a));
    tick();
    tick();
`ifdef JTKIWI_ARB_RR_EN
    chk("last_tie_m_data", 32'(m_dout), 32'(lose_d));
    chk("last_tie_s_data", 32'(s_dout), 32'(win_d));
`else
    chk("last_tie_m_data", 32'(m_dout), 32'(win_d));
    chk("last_tie_s_data", 32'(s_dout), 32'(lose_d));
`endif
    m_cs = 1'b0; s_cs = 1'b0;
    tick();

    // Reset in the middle of a sub read
    s_cs = 1'b1; s_we = 1'b0; s_addr = 13'h1FFF;
    tick();
    chk("mid_rst_granted", 32'(ram_addr), 32'h1FFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(ram_we), 32'h0);
    chk("mid_rst_addr", 32'(ram_addr), 32'h0);
    chk("mid_rst_s_dout", 32'(s_dout), 32'h0);
    chk("mid_rst_s_busy", 32'(s_busy), 32'h1);
    tick();
    tick();
    s_cs = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_s_dout", 32'(s_dout), 32'h0);
    chk("post_rst_addr", 32'(ram_addr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/jtkiwi_shram_arb.md
Name: jtkiwi_shram_arb

Overview:
Arbiter for the 8 kB shared RAM that the main CPU and the sound/sub CPU both access. It sequences single-port RAM accesses, drives a wait/busy line to whichever CPU must stall, and returns per-requester read data. It sits between both Z80 buses and the shared RAM, and feeds the sub CPU's dev_busy input.

Parameters:
AW, 13, RAM address width
DW, 8, data width
RD_LAT, 1, RAM read latency: cycles from ram_addr registered to ram_dout valid (1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m_cs  in  1  main CPU shared-RAM request, level; held until the CPU cycle ends
m_we  in  1  main write strobe, qualified by m_cs
m_addr  in  AW  main address
m_din  in  DW  main write data
m_dout  out  DW  main read data, registered
m_busy  out  1  main wait request
s_cs  in  1  sub CPU request, level
s_we  in  1  sub write strobe
s_addr  in  AW  sub address
s_din  in  DW  sub write data
s_dout  out  DW  sub read data, registered
s_busy  out  1  sub wait request; connects to dev_busy
ram_addr  out  AW  RAM address, registered
ram_din  out  DW  RAM write data, registered
ram_we  out  1  RAM write enable, registered, one-cycle pulse
ram_dout  in  DW  RAM read data

Behaviour:
- Reset, asynchronous: state IDLE, ram_addr=0, ram_din=0, ram_we=0, m_dout=0, s_dout=0, m_done=0, s_done=0, last=SUB (main wins the first tie).
- Per-requester done flag: set when that requester's access completes; cleared on any edge where its cs is low.
- x_busy = x_cs & ~x_done, combinational, so a CPU is stalled in the same cycle it asserts cs.
- FSM states: IDLE, ACC_M, ACC_S.
- IDLE, pending defined as x_cs & ~x_done:
  - only one requester pending: go to its ACC state.
  - both pending: priority rule (see Optional Feature).
  - on the transition edge, register ram_addr and ram_din from the winner, set ram_we = winner's we, and clear the latency counter.
- ACC_x:
  - ram_we is low from the second cycle on, so the write pulse is exactly 1 cycle.
  - Write: on the next edge set x_done and return to IDLE.
  - Read: the counter increments each edge. When it reaches RD_LAT, capture ram_dout into x_dout, set x_done, set last=x and return to IDLE.
  - Writes also update last.
  - The ram_addr/ram_din inputs are ignored while in ACC_x.
- Latency, uncontended, request sampled at edge N:
  - write: ram_we high between edges N and N+1; busy low after edge N+1.
  - read: x_dout valid and busy low after edge N+RD_LAT.
- IDLE→ACC takes no extra cycle. A pending loser is granted on the edge that returns the FSM to IDLE+0, i.e. the IDLE decode is evaluated in the completing state, giving back-to-back accesses.
- Requester drops cs mid-access: the access still completes and the RAM write still happens. The done flag is not set because cs is low; x_dout is still updated.
- Requester holds cs after done: no second access until cs goes low at least one edge.
- x_dout holds its value between accesses.
- Address/data changes while busy are not sampled.

Optional Feature:
JTKIWI_ARB_RR_EN
- Defined: on a tie, grant the requester that is not `last` (round-robin). Neither CPU waits longer than one foreign access.
- Undefined: on a tie the main CPU always wins. `last` is still tracked but ignored.

Test Plan:
- Reset with m_cs=s_cs=1 → all outputs 0, both busy=1 after release. First grant goes to main, since last=SUB.
- Main write addr 0x0A5C data 0x3C, uncontended → ram_we high exactly 1 cycle with ram_addr=0x0A5C, ram_din=0x3C; m_busy low 1 cycle after the sample edge.
- Sub read addr 0x1FFF, RD_LAT=2, RAM returns 0x81 → s_dout=0x81 and s_busy falls 2 edges after the grant.
- Simultaneous reads, same cycle, repeated 4 times:
  - RR_EN defined: grants alternate M,S,M,S.
  - RR_EN undefined: main served first each time; sub served back-to-back right after.
- Sub holds cs 10 cycles after done → exactly one RAM access; a new access only after cs goes low then high.
- Assert rst_n low during ACC_S mid-read → ram_we=0 and state IDLE immediately. s_dout stays 0 and the read is not completed.
